// File: rtl/harvard_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : harvard_bus_sequencer
// Description : Multicycle sequencer sharing one Avalon-style memory bus
//               between a single-cycle datapath's instruction and data ports.
//               Fetches an instruction, performs the optional load/store,
//               then issues exactly one datapath commit pulse. Detects the
//               halt address and bus wait timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module harvard_bus_sequencer #(
    parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 1023,
    parameter int          CNT_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_readdata,
    output logic        datapath_enable,
    output logic        active,
    output logic        bus_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    // Counter value on the last tolerated stall cycle; the next stall edge trips the timeout.
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        FETCH       = 2'd0,
        EXEC        = 2'd1,
        LOAD_COMMIT = 2'd2,
        HALTED      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        ldata_q, ldata_d;
    logic               active_q, active_d;
    logic               error_q, error_d;

    logic               rd_req;
    logic               wr_req;
    logic [31:0]        bus_addr;
    logic [31:0]        bus_wdata;
    logic               stall;
    logic               commit;

    // Bus request decode: strobe, address and write data depend only on state and datapath inputs.
    always_comb begin
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state_q)
            FETCH: begin
                if (instr_address != HALT_ADDR) begin
                    rd_req   = 1'b1;
                    bus_addr = instr_address;
                end
            end
            EXEC: begin
                // A decoder asserting both load and store is handled as a store.
                if (data_write) begin
                    wr_req    = 1'b1;
                    bus_addr  = data_address;
                    bus_wdata = data_writedata;
                end else if (data_read) begin
                    rd_req   = 1'b1;
                    bus_addr = data_address;
                end
            end
            default: ;
        endcase
    end

    assign stall = (rd_req | wr_req) & waitrequest;

    // Next-state, latch and commit logic; a stalled cycle only advances the timeout counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        ldata_d    = ldata_q;
        active_d   = active_q;
        error_d    = error_q;
        commit     = 1'b0;
        if (stall) begin
            if (wait_cnt_q == C_WAIT_LAST) begin
                state_d    = HALTED;
                error_d    = 1'b1;
                active_d   = 1'b0;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end else begin
            wait_cnt_d = '0;
            case (state_q)
                FETCH: begin
                    if (instr_address == HALT_ADDR) begin
                        state_d  = HALTED;
                        active_d = 1'b0;
                    end else begin
                        instr_d = readdata;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (rd_req) begin
                        ldata_d = readdata;
                        state_d = LOAD_COMMIT;
                    end else begin
                        // ALU op, or a store whose transfer completes this cycle.
                        commit  = 1'b1;
                        state_d = FETCH;
                    end
                end
                LOAD_COMMIT: begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
                default: ;
            endcase
        end
    end

    // State and latch registers; everything freezes while clk_enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            instr_q    <= '0;
            ldata_q    <= '0;
            active_q   <= 1'b1;
            error_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            ldata_q    <= ldata_d;
            active_q   <= active_d;
            error_q    <= error_d;
        end
    end

    // Strobes stay up while clk_enable is low so an Avalon transfer is never withdrawn;
    // reset abandons any pending access.
    assign read            = rd_req & ~reset;
    assign write           = wr_req & ~reset;
    assign address         = reset ? 32'h0 : bus_addr;
    assign writedata       = reset ? 32'h0 : bus_wdata;
    assign byteenable      = 4'b1111;
    assign datapath_enable = commit & clk_enable & ~reset;
    assign instr_readdata  = instr_q;
    assign data_readdata   = ldata_q;
    assign active          = active_q;
    assign bus_error       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_harvard_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_harvard_bus_sequencer
// Description : Self-checking bench: directed scenarios with literal
//               expectations plus randomized instruction streams compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_harvard_bus_sequencer;

    localparam logic [31:0] HALT  = 32'h0000_0000;
    localparam int          LIMIT = 15;
    localparam int PH_FETCH = 0, PH_EXEC = 1, PH_LOADC = 2, PH_HALT = 3;

    logic        clk = 1'b0;
    logic        reset, clk_enable;
    logic [31:0] instr_address, data_address, data_writedata, readdata;
    logic        data_read, data_write, waitrequest;
    logic [31:0] instr_readdata, data_readdata, address, writedata;
    logic        datapath_enable, active, bus_error, read, write;
    logic [3:0]  byteenable;

    harvard_bus_sequencer #(
        .HALT_ADDR  (HALT),
        .WAIT_LIMIT (LIMIT),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_readdata   (data_readdata),
        .datapath_enable (datapath_enable),
        .active          (active),
        .bus_error       (bus_error),
        .address         (address),
        .read            (read),
        .write           (write),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .readdata        (readdata),
        .waitrequest     (waitrequest)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: which phase of the current instruction we are in.
    int          m_phase  = PH_HALT;
    int          m_stalls = 0;
    logic [31:0] m_instr  = '0;
    logic [31:0] m_data   = '0;
    logic        m_active = 1'b0;
    logic        m_err    = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_new    = 1'b0;
    int          m_fetches   = 0;
    int          dut_commits = 0;

    // Bus activity the current phase must show, given the present inputs.
    function automatic void bus_expect(output logic e_rd, output logic e_wr, output logic e_de,
                                       output logic [31:0] e_a, output logic [31:0] e_w);
        e_rd = 1'b0; e_wr = 1'b0; e_de = 1'b0; e_a = '0; e_w = '0;
        if (!reset) begin
            if (m_phase == PH_FETCH && instr_address != HALT) begin
                e_rd = 1'b1; e_a = instr_address;
            end else if (m_phase == PH_EXEC && data_write) begin
                e_wr = 1'b1; e_a = data_address; e_w = data_writedata;
                e_de = clk_enable && !waitrequest;
            end else if (m_phase == PH_EXEC && data_read) begin
                e_rd = 1'b1; e_a = data_address;
            end else if (m_phase == PH_EXEC || m_phase == PH_LOADC) begin
                e_de = clk_enable;
            end
        end
    endfunction

    // Model advance at each clock edge.
    always @(posedge clk) begin : model
        logic e_rd, e_wr, e_de;
        logic [31:0] e_a, e_w;
        if (reset) begin
            m_phase = PH_FETCH; m_stalls = 0; m_instr = '0; m_data = '0;
            m_active = 1'b1; m_err = 1'b0; m_valid = 1'b1; m_new = 1'b1; m_fetches = 0;
        end else if (m_valid && clk_enable) begin
            bus_expect(e_rd, e_wr, e_de, e_a, e_w);
            if ((e_rd || e_wr) && waitrequest) begin
                m_stalls++;
                if (m_stalls >= LIMIT) begin
                    m_err = 1'b1; m_active = 1'b0; m_phase = PH_HALT;
                end
            end else begin
                m_stalls = 0;
                case (m_phase)
                    PH_FETCH: begin
                        if (instr_address == HALT) begin
                            m_phase = PH_HALT; m_active = 1'b0;
                        end else begin
                            m_instr = readdata; m_phase = PH_EXEC; m_fetches++;
                        end
                    end
                    PH_EXEC: begin
                        if (!data_write && data_read) begin
                            m_data = readdata; m_phase = PH_LOADC;
                        end else begin
                            m_phase = PH_FETCH; m_new = 1'b1;
                        end
                    end
                    PH_LOADC: begin
                        m_phase = PH_FETCH; m_new = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic e_rd, e_wr, e_de, bad;
        logic [31:0] e_a, e_w;
        if (reset) dut_commits = 0;
        else if (datapath_enable === 1'b1) dut_commits++;
        if (m_valid) begin
            bus_expect(e_rd, e_wr, e_de, e_a, e_w);
            vectors++;
            bad = (read !== e_rd) || (write !== e_wr) || (datapath_enable !== e_de) ||
                  ((e_rd || e_wr) && address !== e_a) || (e_wr && writedata !== e_w) ||
                  (instr_readdata !== m_instr) || (data_readdata !== m_data) ||
                  (active !== m_active) || (bus_error !== m_err) || (byteenable !== 4'hF);
            if (bad) begin
                miscompares++;
                $display("FAIL cycle_compare t=%0t got rd=%b wr=%b de=%b addr=%h wd=%h ir=%h ld=%h act=%b err=%b be=%h expected rd=%b wr=%b de=%b addr=%h wd=%h ir=%h ld=%h act=%b err=%b be=f",
                         $time, read, write, datapath_enable, address, writedata, instr_readdata,
                         data_readdata, active, bus_error, byteenable, e_rd, e_wr, e_de, e_a, e_w,
                         m_instr, m_data, m_active, m_err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin : main
        int cnt_a, cnt_b, de_at;
        logic [31:0] tmp;
        reset = 1'b1; clk_enable = 1'b1; waitrequest = 1'b0;
        instr_address = '0; data_address = '0; data_writedata = '0; readdata = '0;
        data_read = 1'b0; data_write = 1'b0;

        // ALU instruction with no wait states, then jump to the halt address.
        instr_address = 32'hBFC0_0000; readdata = 32'h2442_0001;
        apply_reset();
        at_neg();
        check1("t1_fetch_read", read, 1'b1);
        check("t1_fetch_addr", address, 32'hBFC0_0000);
        check("t1_reset_ir", instr_readdata, 32'h0);
        check("t1_reset_ld", data_readdata, 32'h0);
        check1("t1_reset_active", active, 1'b1);
        check1("t1_reset_err", bus_error, 1'b0);
        check1("t1_no_de_in_fetch", datapath_enable, 1'b0);
        step();
        at_neg();
        check("t1_ir_latched", instr_readdata, 32'h2442_0001);
        check1("t1_de_pulse", datapath_enable, 1'b1);
        check1("t1_no_write", write, 1'b0);
        check1("t1_no_read_exec", read, 1'b0);
        step();
        instr_address = HALT;
        at_neg();
        check1("t4_halt_no_read", read, 1'b0);
        check1("t4_de_single", datapath_enable, 1'b0);
        step();
        cnt_a = 0;
        repeat (20) begin
            at_neg();
            if (active || read || write || datapath_enable) cnt_a++;
            step();
        end
        check("t4_halted_20_cycles_busy", cnt_a, 0);

        // Load with three wait states.
        instr_address = 32'h0000_0100; data_read = 1'b1; data_write = 1'b0;
        data_address = 32'h0000_1000; readdata = 32'h0000_0111;
        apply_reset();
        at_neg();
        step();
        waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            if (read && address == 32'h0000_1000) cnt_a++;
            if (datapath_enable) cnt_b++;
            step();
            if (i == 2) waitrequest = 1'b0;
        end
        check("t2_read_held_cycles", cnt_a, 4);
        check("t2_no_early_de", cnt_b, 0);
        at_neg();
        check("t2_load_data", data_readdata, 32'hDEAD_BEEF);
        check1("t2_load_commit_de", datapath_enable, 1'b1);
        check1("t2_read_dropped", read, 1'b0);

        // Store with two wait states.
        step();
        instr_address = 32'h0000_0104; data_read = 1'b0; data_write = 1'b1;
        data_address = 32'h0000_2004; data_writedata = 32'h1234_5678; readdata = 32'hAC85_0004;
        apply_reset();
        at_neg();
        step();
        waitrequest = 1'b1;
        cnt_a = 0; cnt_b = 0; de_at = -1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            if (write && address == 32'h0000_2004 && writedata == 32'h1234_5678) cnt_a++;
            if (read) cnt_b++;
            if (datapath_enable) de_at = i;
            step();
            if (i == 1) waitrequest = 1'b0;
        end
        check("t3_write_held_cycles", cnt_a, 3);
        check("t3_no_read_in_store", cnt_b, 0);
        check("t3_de_cycle", de_at, 2);
        at_neg();
        check1("t3_write_dropped", write, 1'b0);

        // Stuck waitrequest trips the timeout.
        step();
        instr_address = 32'h0000_0200; data_read = 1'b0; data_write = 1'b0; waitrequest = 1'b1;
        apply_reset();
        cnt_a = 0;
        for (int i = 0; i < LIMIT; i++) begin
            at_neg();
            if (read && active && !bus_error) cnt_a++;
            step();
        end
        check("t5_stalled_cycles", cnt_a, LIMIT);
        at_neg();
        check1("t5_bus_error", bus_error, 1'b1);
        check1("t5_read_dropped", read, 1'b0);
        check1("t5_inactive", active, 1'b0);

        // clk_enable low mid-fetch, then reset in the middle of a load.
        step();
        instr_address = 32'h0000_0300; waitrequest = 1'b0; readdata = 32'hA0A0_0001;
        apply_reset();
        at_neg(); step();
        at_neg(); step();
        instr_address = 32'h0000_0304; readdata = 32'hB0B0_0002; clk_enable = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            if (read && address == 32'h0000_0304 && instr_readdata == 32'hA0A0_0001 && !datapath_enable)
                cnt_a++;
            step();
        end
        check("t6_hold_cycles", cnt_a, 5);
        clk_enable = 1'b1; data_read = 1'b1; data_address = 32'h0000_1000;
        at_neg(); step();
        waitrequest = 1'b1;
        at_neg();
        check("t6_ir_after_enable", instr_readdata, 32'hB0B0_0002);
        check("t6_load_addr", address, 32'h0000_1000);
        step();
        at_neg(); step();
        reset = 1'b1;
        at_neg();
        check1("t6_reset_read_drop", read, 1'b0);
        step();
        at_neg();
        check("t6_reset_ir", instr_readdata, 32'h0);
        check("t6_reset_ld", data_readdata, 32'h0);
        check1("t6_reset_active", active, 1'b1);
        check1("t6_reset_err", bus_error, 1'b0);
        check1("t6_reset_de", datapath_enable, 1'b0);
        step();
        reset = 1'b0; waitrequest = 1'b0;
        at_neg();
        check1("t6_refetch_read", read, 1'b1);
        check("t6_refetch_addr", address, 32'h0000_0304);
        step();

        // Randomized instruction streams; segments 3 and 7 stall heavily to provoke timeouts.
        for (int seg = 0; seg < 8; seg++) begin
            int stall_pct;
            stall_pct = (seg % 4 == 3) ? 90 : 25;
            clk_enable = 1'b1; waitrequest = 1'b0;
            apply_reset();
            for (int c = 0; c < 300; c++) begin
                if (m_new) begin
                    m_new = 1'b0;
                    tmp = $urandom;
                    tmp[1:0] = 2'b00;
                    instr_address = ($urandom_range(39) == 0) ? HALT : tmp;
                    cnt_a = $urandom_range(9);
                    data_read  = (cnt_a >= 4 && cnt_a <= 6) || cnt_a == 9;
                    data_write = (cnt_a >= 7);
                    data_address   = $urandom;
                    data_writedata = $urandom;
                end
                waitrequest = ($urandom_range(99) < stall_pct);
                readdata    = $urandom;
                clk_enable  = ($urandom_range(99) < 85);
                step();
            end
            vectors++;
            if (dut_commits > m_fetches || dut_commits + 1 < m_fetches) begin
                miscompares++;
                $display("FAIL commit_count seg %0d: got %0d commits for %0d fetches, required fetches-1..fetches",
                         seg, dut_commits, m_fetches);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
